// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pixel/coordinate types and the colour-bar table.
package vga_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef logic signed [10:0] coord_t;

    // Left-to-right bar order of the built-in test pattern, RRRGGGBB.
    localparam logic [7:0] BAR_COLOURS [0:7] = '{
        8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00
    };

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register whose taps clear asynchronously to CLR_VAL.
module vga_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] taps [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) taps[i] <= CLR_VAL;
        end else begin
            taps[0] <= din;
            for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
        end
    end

    assign dout = taps[DEPTH-1];

endmodule

// File: rtl/vga_out_stage.sv
// 640x480@60 timing generator and DAC output register with sync/blank aligned to
// the drawing pipeline. Optional colour bars under macro VGA_TEST_PATTERN_EN.
module vga_out_stage
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter int PIPE_DELAY = 2
) (
    input  logic               clk,
    input  logic               reset,
    output logic signed [10:0] pixelX,
    output logic signed [10:0] pixelY,
    output logic               startOfFrame,
    input  logic [7:0]         RGBIn,
    input  logic               testPattern,
    output logic [3:0]         vgaR,
    output logic [3:0]         vgaG,
    output logic [3:0]         vgaB,
    output logic               hSync,
    output logic               vSync,
    output logic               blankN
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    function automatic logic [3:0] expand3(input logic [2:0] c);
        return {c, c[2]};
    endfunction

    function automatic logic [3:0] expand2(input logic [1:0] c);
        return {c, c};
    endfunction

    logic [10:0] hCnt;
    logic [10:0] vCnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hCnt         <= '0;
            vCnt         <= '0;
            pixelX       <= '0;
            pixelY       <= '0;
            startOfFrame <= 1'b0;
        end else begin
            if (hCnt == H_LAST) begin
                hCnt <= '0;
                vCnt <= (vCnt == V_LAST) ? 11'd0 : vCnt + 11'd1;
            end else begin
                hCnt <= hCnt + 11'd1;
            end
            pixelX       <= coord_t'(hCnt);
            pixelY       <= coord_t'(vCnt);
            startOfFrame <= (hCnt == 11'd0) && (vCnt == 11'd0);
        end
    end

    // ---- stage 0: decode of the coordinate currently on pixelX/pixelY ----
    logic [10:0] x_p0;
    logic [10:0] y_p0;
    logic        act_p0;
    logic        hs_p0;
    logic        vs_p0;

    assign x_p0   = pixelX;
    assign y_p0   = pixelY;
    assign act_p0 = (x_p0 < H_ACT) && (y_p0 < V_ACT);
    assign hs_p0  = !((x_p0 >= HS_START) && (x_p0 < HS_END));
    assign vs_p0  = !((y_p0 >= VS_START) && (y_p0 < VS_END));

    // ---- stage 1: controls delayed by PIPE_DELAY to meet RGBIn ----
    logic act_p1;
    logic hs_p1;
    logic vs_p1;

    vga_delay_line #(
        .WIDTH  (3),
        .DEPTH  (PIPE_DELAY),
        .CLR_VAL(3'b011)
    ) u_ctrl_dly (
        .clk  (clk),
        .reset(reset),
        .din  ({act_p0, hs_p0, vs_p0}),
        .dout ({act_p1, hs_p1, vs_p1})
    );

    rgb332_t pix_p1;
    rgb332_t sel_p1;

    assign pix_p1 = RGBIn;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

    logic [10:0] x_p1;
    logic [10:0] bar_q;
    logic [2:0]  bar_idx;

    vga_delay_line #(
        .WIDTH  (11),
        .DEPTH  (PIPE_DELAY),
        .CLR_VAL(11'd0)
    ) u_x_dly (
        .clk  (clk),
        .reset(reset),
        .din  (x_p0),
        .dout (x_p1)
    );

    assign bar_q   = x_p1 / BAR_W;
    assign bar_idx = (bar_q > 11'd7) ? 3'd7 : bar_q[2:0];
    assign sel_p1  = testPattern ? rgb332_t'(BAR_COLOURS[bar_idx]) : pix_p1;
`else
    logic unused_test_pattern;

    assign unused_test_pattern = testPattern;
    assign sel_p1              = pix_p1;
`endif

    // ---- stage 2: output register, colour forced dark outside the active area ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vgaR   <= '0;
            vgaG   <= '0;
            vgaB   <= '0;
            hSync  <= 1'b1;
            vSync  <= 1'b1;
            blankN <= 1'b0;
        end else begin
            blankN <= act_p1;
            hSync  <= hs_p1;
            vSync  <= vs_p1;
            if (act_p1) begin
                vgaR <= expand3(sel_p1.r);
                vgaG <= expand3(sel_p1.g);
                vgaB <= expand2(sel_p1.b);
            end else begin
                vgaR <= '0;
                vgaG <= '0;
                vgaB <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_out_stage.sv
// Directed bench: full-size instance for line timing/colour, reduced-timing
// instance for frame wrap, vSync and startOfFrame periodicity.
module tb_vga_out_stage;
    import vga_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] rgbA = 8'hE0;
    logic tpA = 1'b0;

    logic signed [10:0] pxA, pyA, pxB, pyB;
    logic sofA, sofB;
    logic [3:0] rA, gA, bA, rB, gB, bB;
    logic hsA, vsA, blA, hsB, vsB, blB;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int hs_low = 0;
    int vsb_low = 0;
    int sofb_cnt = 0;

    always #5 clk = ~clk;

    vga_out_stage dutA (
        .clk(clk), .reset(reset), .pixelX(pxA), .pixelY(pyA), .startOfFrame(sofA),
        .RGBIn(rgbA), .testPattern(tpA), .vgaR(rA), .vgaG(gA), .vgaB(bA),
        .hSync(hsA), .vSync(vsA), .blankN(blA)
    );

    vga_out_stage #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .PIPE_DELAY(3)
    ) dutB (
        .clk(clk), .reset(reset), .pixelX(pxB), .pixelY(pyB), .startOfFrame(sofB),
        .RGBIn(8'hFF), .testPattern(1'b0), .vgaR(rB), .vgaG(gB), .vgaB(bB),
        .hSync(hsB), .vSync(vsB), .blankN(blB)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance to edge number t since reset release, sampling 1 time unit after each edge.
    task automatic go(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!hsA) hs_low++;
            if (!vsB) vsb_low++;
            if (sofB) sofb_cnt++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_px", pxA, 0);
        check("rst_py", pyA, 0);
        check("rst_sof", sofA, 0);
        check("rst_r", rA, 0);
        check("rst_blank", blA, 0);
        check("rst_hs", hsA, 1);
        check("rst_vs", vsA, 1);

        @(negedge clk);
        reset = 1'b0;

        go(1);
        check("sof_first", sofA, 1);
        check("px_first", pxA, 0);
        check("sofB_first", sofB, 1);
        go(2);
        check("px_1", pxA, 1);
        check("sof_drop", sofA, 0);
        go(10);
        check("act_blank", blA, 1);
        check("act_r", rA, 4'hF);
        check("act_g", gA, 0);
        check("act_b", bA, 0);
        check("act_hs", hsA, 1);
        check("act_vs", vsA, 1);

        go(79);
        check("vsB_pre", vsB, 1);
        go(80);
        check("vsB_start", vsB, 0);
        go(109);
        check("vsB_last", vsB, 0);
        go(110);
        check("vsB_end", vsB, 1);
        go(120);
        check("vsB_width", vsb_low, 30);
        check("pyB_last", pyB, 7);
        go(121);
        check("sofB_frame2", sofB, 1);
        check("pyB_wrap", pyB, 0);
        go(360);
        check("sofB_count", sofb_cnt, 3);

        go(640);
        check("px_639", pxA, 639);
        go(643);
        check("lit_639_blank", blA, 1);
        check("lit_639_r", rA, 4'hF);
        go(644);
        check("dark_640_blank", blA, 0);
        check("dark_640_r", rA, 0);

        go(657);
        check("px_656", pxA, 656);
        go(659);
        check("hs_pre", hsA, 1);
        go(660);
        check("hs_start", hsA, 0);
        go(755);
        check("hs_last", hsA, 0);
        go(756);
        check("hs_end", hsA, 1);

        go(H_TOTAL_DEF);
        check("px_799", pxA, 799);
        check("py_line0", pyA, 0);
        check("hs_width", hs_low, 96);
        go(801);
        check("px_wrap", pxA, 0);
        check("py_inc", pyA, 1);
        check("sof_not_line", sofA, 0);

        go(810);
        rgbA = 8'h49;
        go(811);
        check("c49_r", rA, 4'h4);
        check("c49_g", gA, 4'h4);
        check("c49_b", bA, 4'h5);
        go(820);
        rgbA = 8'h92;
        go(821);
        check("c92_r", rA, 4'h9);
        check("c92_g", gA, 4'h9);
        check("c92_b", bA, 4'hA);

        go(880);
        rgbA = 8'hE0;
        tpA = 1'b1;
        go(889);
`ifdef VGA_TEST_PATTERN_EN
        check("tp85_r", rA, 4'hF);
        check("tp85_g", gA, 4'hF);
        check("tp85_b", bA, 4'h0);
`else
        check("tp85_r", rA, 4'hF);
        check("tp85_g", gA, 4'h0);
        check("tp85_b", bA, 4'h0);
`endif
        tpA = 1'b0;
        go(890);
        check("tp_off_r", rA, 4'hF);
        check("tp_off_g", gA, 4'h0);

        go(1501);
        check("px_700", pxA, 700);
        check("hs_mid_low", hsA, 0);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_px", pxA, 0);
        check("mid_rst_py", pyA, 0);
        check("mid_rst_hs", hsA, 1);
        check("mid_rst_blank", blA, 0);
        check("mid_rst_r", rA, 0);
        check("mid_rst_sof", sofA, 0);

        @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        hs_low = 0;
        go(1);
        check("restart_sof", sofA, 1);
        check("restart_px", pxA, 0);
        check("restart_py", pyA, 0);
        go(659);
        check("restart_no_hs", hs_low, 0);
        go(660);
        check("restart_hs", hsA, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
